math_divider_8bit_seq: RTL and testbench

- Sequential unsigned integer divider: the inverse operation of the calculator's combinational 8-bit multiplier.
- Computes quotient and remainder of an 8-bit dividend by an 8-bit divisor.
- Uses a radix-2 restoring algorithm, one quotient bit per clock.
- Driven by the calculator FSM through a start/busy/done handshake; results stay held for the FSM to read.

---
 rtl/math_divider_8bit_seq.sv | 136 +++++++++++++
 tb/tb_math_divider_8bit_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/math_divider_8bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake,
// results held until the next completion. Divide-by-zero returns all-ones quotient and a as remainder.

module math_divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             msb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             qbit_o
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Extra remainder bit keeps the trial subtract from wrapping.
   always_comb begin
      shifted = (rem_i << 1) | {{WIDTH{1'b0}}, msb_i};
      diff    = shifted - {1'b0, divisor_i};
      qbit_o  = (shifted >= {1'b0, divisor_i});
      rem_o   = qbit_o ? diff : shifted;
   end
endmodule

module math_divider_8bit_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] divQuotient,
   output logic [WIDTH-1:0] divRemainder,
   output logic             busy,
   output logic             done,
   output logic             divByZero
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_res_q, quot_res_d;
   logic [WIDTH-1:0] rem_res_q, rem_res_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   rem_nxt;
   logic             qbit;

   math_divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .msb_i     (dividend_q[WIDTH-1]),
      .divisor_i (divisor_q),
      .rem_o     (rem_nxt),
      .qbit_o    (qbit)
   );

   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      quot_res_d = quot_res_q;
      rem_res_d  = rem_res_q;
      dbz_d      = dbz_q;
      case (state_q)
         S_CALC: begin
            // Quotient bits fill the dividend register from the LSB as it empties out the MSB.
            dividend_d = {dividend_q[WIDTH-2:0], qbit};
            rem_d      = rem_nxt;
            cnt_d      = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d    = S_DONE;
               quot_res_d = {dividend_q[WIDTH-2:0], qbit};
               rem_res_d  = rem_nxt[WIDTH-1:0];
            end
         end
         default: begin
            // IDLE and DONE both accept a new request.
            if (start) begin
               dividend_d = a;
               divisor_d  = b;
               rem_d      = '0;
               cnt_d      = CW'(WIDTH);
               dbz_d      = 1'b0;
               if (b == '0) begin
                  state_d    = S_DONE;
                  quot_res_d = '1;
                  rem_res_d  = a;
                  dbz_d      = 1'b1;
               end else begin
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         quot_res_q <= '0;
         rem_res_q  <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         quot_res_q <= quot_res_d;
         rem_res_q  <= rem_res_d;
         dbz_q      <= dbz_d;
      end
   end

   assign divQuotient  = quot_res_q;
   assign divRemainder = rem_res_q;
   assign divByZero    = dbz_q;
   assign busy         = (state_q == S_CALC);
   assign done         = (state_q == S_DONE);
endmodule

// File: tb/tb_math_divider_8bit_seq.sv
// Bench for math_divider_8bit_seq: vector table, handshake corner sequences and a sampled sweep,
// with results checked through an expectation queue popped on each done pulse.
`timescale 1ns/1ps
module tb_math_divider_8bit_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic [7:0] divQuotient, divRemainder;
   logic       busy, done, divByZero;

   typedef struct {
      logic [7:0] a, b, q, r;
      logic       dbz;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[12];
   int   n_cmp = 0;
   int   n_err = 0;

   math_divider_8bit_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .divQuotient(divQuotient), .divRemainder(divRemainder),
      .busy(busy), .done(done), .divByZero(divByZero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic vec_t model(input logic [7:0] av, input logic [7:0] bv);
      vec_t e;
      e.a = av; e.b = bv;
      if (bv == 0) begin
         e.q = 8'hFF; e.r = av; e.dbz = 1'b1;
      end else begin
         e.q = av / bv; e.r = av % bv; e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Result scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: actual=done required=no_done at %0t", $time);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            chk($sformatf("result_%0d_div_%0d", e.a, e.b),
                {divQuotient, divRemainder, divByZero}, {e.q, e.r, e.dbz});
         end
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_q"},    divQuotient, 0);
      chk({tag, "_r"},    divRemainder, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_dbz"},  divByZero, 0);
   endtask

   // Called at a negedge; returns at the negedge where done is seen so the next call lands in DONE.
   task automatic run_div(input vec_t e);
      int lat, nb;
      bit seen;
      exp_q.push_back(e);
      a = e.a; b = e.b; start = 1'b1;
      lat = 0; nb = 0; seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (lat == 1) chk("dbz_after_start", divByZero, (e.b == 0));
         if (done) begin seen = 1; break; end
         nb += busy;
      end
      if (!seen) chk("done_timeout", 0, 1);
      chk("latency", lat, (e.b == 0) ? 1 : 9);
      chk("busy_cycles", nb, (e.b == 0) ? 0 : 8);
   endtask

   initial begin
      logic [7:0] bnd[7];
      int lat, cnt;
      bnd = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
      tbl[0]  = '{170, 85,  2,   0, 1'b0};
      tbl[1]  = '{255, 16,  15,  15, 1'b0};
      tbl[2]  = '{255, 1,   255, 0, 1'b0};
      tbl[3]  = '{5,   9,   0,   5, 1'b0};
      tbl[4]  = '{7,   0,   255, 7, 1'b1};
      tbl[5]  = '{30,  2,   15,  0, 1'b0};
      tbl[6]  = '{0,   1,   0,   0, 1'b0};
      tbl[7]  = '{255, 255, 1,   0, 1'b0};
      tbl[8]  = '{0,   0,   255, 0, 1'b1};
      tbl[9]  = '{128, 127, 1,   1, 1'b0};
      tbl[10] = '{254, 128, 1,   126, 1'b0};
      tbl[11] = '{100, 7,   14,  2, 1'b0};

      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) run_div(tbl[i]);

      // Results hold through idle cycles.
      repeat (4) @(negedge clk);
      chk("hold_q", divQuotient, 14);
      chk("hold_r", divRemainder, 2);
      chk("hold_busy", busy, 0);

      // Start during CALC is ignored and operand changes do not disturb the result.
      exp_q.push_back('{200, 3, 66, 2, 1'b0});
      a = 200; b = 3; start = 1'b1;
      @(negedge clk); start = 1'b0; lat = 1;
      repeat (2) @(negedge clk);
      lat += 2;
      a = 9; b = 9; start = 1'b1;
      @(negedge clk); start = 1'b0; lat++;
      a = 8'($urandom); b = 8'($urandom);
      cnt = 0;
      while (!done && cnt < 20) begin @(negedge clk); lat++; cnt++; end
      chk("ignore_latency", lat, 9);
      run_div('{128, 128, 1, 0, 1'b0});

      // Reset in the 4th CALC cycle aborts without a done pulse.
      a = 100; b = 7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_state("abort");
      rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin @(negedge clk); cnt += done; end
      chk("abort_no_done", cnt, 0);
      run_div('{100, 7, 14, 2, 1'b0});

      foreach (bnd[i]) foreach (bnd[j]) run_div(model(bnd[i], bnd[j]));
      for (int i = 0; i < 256; i++) run_div(model(8'(i), 8'd0));
      for (int i = 0; i < 2500; i++) run_div(model(8'($urandom), 8'($urandom_range(1, 255))));

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
